// File: rtl/if_fetch_unit.sv
// Instruction fetch stage.
//   Owns the sequential fetch PC and issues word requests to instruction
//   memory. Memory answers in order, with no backpressure. Returned words
//   are buffered in a DEPTH-entry queue. The queue head is presented to
//   decode as {inst_data, inst_pc}.
//   A redirect moves the fetch PC and the head PC to the new target,
//   flushes the queue, and marks every in-flight response for discard.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   imem_req_valid/ready/addr      request channel to instruction memory
//   imem_rsp_valid/data            in-order response channel
//   redirect_valid/pc              single-cycle redirect strobe and target
//   inst_valid/ready/data/pc       handshake to decode
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   head_pc;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] occ;
  logic [CW-1:0] pend;
  logic [CW-1:0] drop;

  logic [CW:0]   used;
  logic          accept;
  logic          rsp_ok;
  logic          rsp_drop;
  logic          push;
  logic          pop;
  logic [CW-1:0] pend_nxt;
  logic [31:0]   target;

  always_comb begin
    used           = {1'b0, occ} + {1'b0, pend};
    // Credit is taken from registered occ/pend only, so a pop in this
    // cycle frees its slot for the next cycle, not this one.
    imem_req_valid = rst_n && (used < DEPTH_W) && !redirect_valid;
    imem_req_addr  = fetch_pc;
    accept         = imem_req_valid && imem_req_ready;
    // A response with nothing pending is a protocol violation and is ignored.
    rsp_ok         = imem_rsp_valid && (pend != '0);
    rsp_drop       = rsp_ok && (drop != '0);
    push           = rsp_ok && !rsp_drop && !redirect_valid;
    inst_valid     = (occ != '0);
    inst_data      = mem[rd_ptr];
    inst_pc        = head_pc;
    pop            = inst_valid && inst_ready && !redirect_valid;
    pend_nxt       = pend + CW'(accept) - CW'(rsp_ok);
    target         = {redirect_pc[31:2], 2'b00};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      head_pc  <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      occ      <= '0;
      pend     <= '0;
      drop     <= '0;
    end else if (redirect_valid) begin
      // Nothing is accepted in a redirect cycle. Any response arriving in
      // this cycle is dropped here, and every request still pending becomes
      // a response to discard. Those requests keep their credit until the
      // responses come back.
      fetch_pc <= target;
      head_pc  <= target;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      occ      <= '0;
      pend     <= pend_nxt;
      drop     <= pend_nxt;
    end else begin
      if (accept) fetch_pc <= fetch_pc + 32'd4;
      if (pop) begin
        head_pc <= head_pc + 32'd4;
        rd_ptr  <= rd_ptr + AW'(1);
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      occ  <= occ + CW'(push) - CW'(pop);
      pend <= pend_nxt;
      if (rsp_drop) drop <= drop - CW'(1);
    end
  end

  // Storage needs no reset: occ gates every read of it.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= imem_rsp_data;
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  if_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc)
  );

  always #5 clk = ~clk;

  // Memory contents: a fixed function of the word address.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_F00D;
  endfunction

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          live;
  } req_t;

  req_t        infl[$];      // accepted requests awaiting a response
  int          model_occ;    // live words delivered, not yet consumed
  logic [31:0] exp_fetch;    // next request address
  logic [31:0] exp_head;     // next PC decode must see
  int          cyc = 0;
  int          last_due;
  int          acc_cnt;
  bit          hold_v;
  logic [31:0] hold_pc, hold_data;
  bit          prev_redir;
  int          lat_min, lat_max, rdy_pct, ird_pct, redir_pct;
  bit          full_rate;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    infl.delete();
    model_occ  = 0;
    exp_fetch  = RESET_PC;
    exp_head   = RESET_PC;
    last_due   = 0;
    acc_cnt    = 0;
    hold_v     = 1'b0;
    prev_redir = 1'b0;
  endtask

  task automatic do_reset();
    #2;
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    #1;
    chk("reset_req_valid", 32'(imem_req_valid), 32'd0);
    chk("reset_inst_valid", 32'(inst_valid), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock cycle: drive at the falling edge, check #1 later, and advance
  // the reference model across the rising edge.
  task automatic step(input bit force_redir, input logic [31:0] rpc);
    bit          redir, rsp, pop, acc;
    logic [31:0] tgt;
    int          lat, due;
    req_t        e;
    @(negedge clk);
    redir = force_redir || ($urandom_range(99) < redir_pct);
    tgt   = force_redir ? rpc : $urandom;
    rsp   = (infl.size() > 0) && (infl[0].due <= cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? word_at(infl[0].addr) : $urandom;
    redirect_valid = redir;
    redirect_pc    = tgt;
    imem_req_ready = ($urandom_range(99) < rdy_pct);
    inst_ready     = ($urandom_range(99) < ird_pct);
    #1;
    if (prev_redir) chk("empty_after_redirect", 32'(inst_valid), 32'd0);
    chk("inst_valid", 32'(inst_valid), 32'(model_occ > 0));
    if (hold_v) begin
      chk("hold_pc", inst_pc, hold_pc);
      chk("hold_data", inst_data, hold_data);
    end
    chk("req_valid", 32'(imem_req_valid),
        32'(((model_occ + infl.size()) < DEPTH) && !redir));
    if (imem_req_valid) chk("req_addr", imem_req_addr, exp_fetch);
    if (full_rate) chk("full_rate", 32'(inst_valid), 32'd1);
    pop = inst_valid && inst_ready && !redir;
    if (pop) begin
      chk("inst_pc", inst_pc, exp_head);
      chk("inst_data", inst_data, word_at(exp_head));
    end
    acc       = imem_req_valid && imem_req_ready;
    hold_v    = inst_valid && !inst_ready && !redir;
    hold_pc   = inst_pc;
    hold_data = inst_data;
    @(posedge clk);
    if (rsp) begin
      e = infl.pop_front();
      if (e.live && !redir) model_occ++;
    end
    if (pop) begin
      model_occ--;
      exp_head += 32'd4;
    end
    if (acc) begin
      lat = $urandom_range(lat_max, lat_min);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      infl.push_back('{addr: exp_fetch, due: due, live: 1'b1});
      exp_fetch += 32'd4;
      acc_cnt++;
    end
    if (redir) begin
      model_occ = 0;
      foreach (infl[i]) infl[i].live = 1'b0;
      exp_fetch = {tgt[31:2], 2'b00};
      exp_head  = {tgt[31:2], 2'b00};
    end
    prev_redir = redir;
    cyc++;
  endtask

  task automatic set_mode(input int lmin, input int lmax, input int rdy, input int ird, input int rdr);
    lat_min = lmin; lat_max = lmax; rdy_pct = rdy; ird_pct = ird; redir_pct = rdr;
  endtask

  initial begin
    full_rate = 1'b0;
    set_mode(1, 1, 100, 100, 0);
    model_reset();
    do_reset();

    // Streaming: latency 1, always ready, decode always ready.
    for (int i = 0; i < 30; i++) begin
      full_rate = (i >= 4);
      step(1'b0, '0);
    end
    full_rate = 1'b0;

    // Decode stalled from reset: the queue fills, then fetch stops.
    do_reset();
    set_mode(1, 1, 100, 0, 0);
    repeat (12) step(1'b0, '0);
    #1;
    chk("stall_accepts", 32'(acc_cnt), 32'd4);
    chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
    chk("stall_pc", inst_pc, RESET_PC);
    chk("stall_data", inst_data, word_at(RESET_PC));
    set_mode(1, 1, 100, 100, 0);
    repeat (12) step(1'b0, '0);

    // Redirect with two requests in flight and one buffered word.
    do_reset();
    set_mode(2, 2, 100, 0, 0);
    repeat (3) step(1'b0, '0);
    step(1'b1, 32'h0000_0100);
    set_mode(1, 3, 100, 100, 0);
    repeat (15) step(1'b0, '0);

    // Randomized traffic with frequent redirects.
    set_mode(1, 3, 70, 70, 10);
    repeat (400) step(1'b0, '0);

    // Misaligned redirect target.
    set_mode(1, 2, 100, 100, 0);
    step(1'b1, 32'h0000_0103);
    repeat (10) step(1'b0, '0);

    // Memory not ready: the request is held, then reset mid-stream.
    do_reset();
    set_mode(1, 1, 100, 100, 0);
    repeat (3) step(1'b0, '0);
    set_mode(1, 1, 0, 100, 0);
    repeat (5) step(1'b0, '0);
    #1;
    chk("held_req_valid", 32'(imem_req_valid), 32'd1);
    do_reset();
    set_mode(1, 3, 80, 80, 0);
    step(1'b0, '0);
    chk("restart_addr", imem_req_addr, RESET_PC);
    repeat (20) step(1'b0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction fetch stage: owns the sequential fetch PC and issues word requests to instruction memory over a valid/ready request channel with in-order responses.
- Buffers returned words in a small queue and presents {instruction, PC} to decode over a valid/ready handshake.
- Decode drives the immediate generator and the rest of ID from `inst_data`.
- Supports redirect (branch/jump target) with flush of the queue and discard of in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 4, queue entries and maximum in-flight plus buffered words; power of 2, at least 2.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  32  word-aligned fetch address.
- imem_rsp_valid  in  1  response valid; one per accepted request, in order, at least 1 cycle after acceptance, no backpressure.
- imem_rsp_data  in  32  instruction word.
- redirect_valid  in  1  single-cycle redirect strobe.
- redirect_pc  in  32  new fetch target; bits [1:0] are ignored and treated as 0.
- inst_valid  out  1  queue head holds a valid instruction.
- inst_ready  in  1  decode consumes head.
- inst_data  out  32  head instruction word.
- inst_pc  out  32  PC of head instruction.

Behaviour:
- State:
  - fetch_pc: next request address.
  - head_pc: PC of queue head.
  - Queue of DEPTH words with occupancy `occ`.
  - pend: accepted, unanswered requests, including ones to be dropped.
  - drop: responses still to discard.
- Reset (rst_n low, asynchronous):
  - fetch_pc = head_pc = RESET_PC; occ = pend = drop = 0.
  - imem_req_valid = 0 and inst_valid = 0 while reset is asserted.
- Request issue:
  - imem_req_valid = (occ + pend < DEPTH) && !redirect_valid; imem_req_addr = fetch_pc.
  - A pop in the same cycle does not free credit; the credit is seen next cycle.
  - Accept is imem_req_valid && imem_req_ready → fetch_pc += 4 (wraps mod 2^32), pend += 1.
  - While the request is unaccepted, addr and valid are held stable; the only withdrawal is in a redirect cycle.
- Response:
  - If imem_rsp_valid and drop > 0 → discard, drop -= 1, pend -= 1.
  - Else push the word into the queue tail, pend -= 1.
  - A response with pend == 0 is a protocol violation and is ignored.
- Output to decode:
  - inst_valid = (occ > 0); inst_data = queue head; inst_pc = head_pc.
  - Pop on inst_valid && inst_ready → occ -= 1, head_pc += 4.
  - inst_data and inst_pc are stable while inst_valid && !inst_ready.
  - Zero added latency beyond the queue: a response pushed in cycle N is visible at the head in cycle N+1.
  - Simultaneous push and pop are allowed; the queue never overflows by construction.
- Redirect (redirect_valid high), taking priority over every other update:
  - fetch_pc = head_pc = redirect_pc & ~3; occ = 0.
  - Any same-cycle pop is void.
  - No request is issued that cycle.
  - drop = pend_next = pend − imem_rsp_valid: a response arriving in the redirect cycle is discarded, and all other in-flight responses are marked for discard.
  - Back-to-back redirects are legal; each one recomputes drop the same way.
  - Credits stay consumed by to-be-dropped requests until their responses return.
- Counters:
  - occ is 0..DEPTH; pend and drop are 0..DEPTH.
  - Counter width is clog2(DEPTH)+1.
- Throughput: with DEPTH ≥ 2 × memory latency + 1, one instruction per cycle is sustained at inst_ready = 1.

Test Plan:
1. RESET_PC=0x8000_0000, memory always ready, latency 1, inst_ready=1 → request addresses 0x8000_0000, _0004, _0008 …; inst_pc follows the same sequence with matching inst_data; after fill, one instruction per cycle.
2. inst_ready=0 from reset → exactly 4 requests accepted, then imem_req_valid=0 with occ=4; inst_data/inst_pc held at 0x8000_0000; releasing inst_ready delivers 4 in order, then fetch resumes at 0x8000_0010.
3. Redirect to 0x0000_0100 while pend=2 and the queue holds 1 word → queue empty next cycle; the 2 stale responses are discarded; the first delivered instruction has inst_pc=0x100; the next request address is 0x100.
4. Redirect coinciding with a response and a decode pop → response discarded, pop ignored, drop = pend−1; first delivered instruction has inst_pc = new target.
5. redirect_pc=0x0000_0103 → requests start at 0x100; inst_pc=0x100.
6. imem_req_ready=0 for 5 cycles → imem_req_valid stays 1 with imem_req_addr constant. Asserting rst_n low mid-stream then forces imem_req_valid=0 and inst_valid=0 immediately; after release, fetch restarts at RESET_PC.
